// File: rtl/uart_axil_responder.sv
`timescale 1ns/1ps
// uart_axil_responder: AXI4-Lite four-register front end (RX_FIFO, TX_FIFO, STATUS, CTRL) for a byte UART.
// Latency: write response the cycle after AW and W are both accepted; read data two cycles after AR.
// Backpressure: AW/W/AR stall while a request or response is outstanding; RX side has none, overflow drops.

// Byte FIFO used for both directions. A clear beats any push or pop issued in the same
// cycle. A pop on empty is ignored. A push on full is taken only if a pop retires at the same time.
module uart_axil_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full,
  output logic       push_ok
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign dout    = mem_q[rd_ptr_q];
  assign push_ok = push && !clr && (!full || do_pop);

  // Pointer and occupancy update; pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    do_pop   = pop && !empty && !clr;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_ok && !do_pop)      cnt_d = cnt_q + 1'b1;
      else if (!push_ok && do_pop) cnt_d = cnt_q - 1'b1;
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset; occupancy decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end
endmodule

module uart_axil_responder #(
  parameter int ADDRW = 4,
  parameter int DATAW = 32,
  parameter int DEPTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               awvalid,
  output logic               awready,
  input  logic [ADDRW-1:0]   awaddr,
  input  logic               wvalid,
  output logic               wready,
  input  logic [DATAW-1:0]   wdata,
  input  logic [DATAW/8-1:0] wstrb,
  output logic               bvalid,
  input  logic               bready,
  output logic [1:0]         bresp,
  input  logic               arvalid,
  output logic               arready,
  input  logic [ADDRW-1:0]   araddr,
  output logic               rvalid,
  input  logic               rready,
  output logic [DATAW-1:0]   rdata,
  output logic [1:0]         rresp,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic [7:0]         tx_data,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  output logic               irq
);
  localparam logic [1:0] SEL_RX     = 2'd0;
  localparam logic [1:0] SEL_TX     = 2'd1;
  localparam logic [1:0] SEL_STATUS = 2'd2;
  localparam logic [1:0] SEL_CTRL   = 2'd3;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_SLV   = 2'b10;

  logic             aw_held_q, aw_held_d;
  logic [1:0]       awsel_q, awsel_d;
  logic             w_held_q, w_held_d;
  logic [7:0]       wbyte_q, wbyte_d;
  logic             wstb_q, wstb_d;
  logic             bvalid_q, bvalid_d;
  logic [1:0]       bresp_q, bresp_d;
  logic             ar_pending_q, ar_pending_d;
  logic [1:0]       arsel_q, arsel_d;
  logic             rvalid_q, rvalid_d;
  logic [1:0]       rresp_q, rresp_d;
  logic [DATAW-1:0] rdata_q, rdata_d;
  logic             ie_q, ie_d;
  logic             ovr_q, ovr_d;
  logic             rx_empty_prev_q, rx_empty_prev_d;
  logic             tx_empty_prev_q, tx_empty_prev_d;
  logic             irq_q, irq_d;

  logic       aw_hs, w_hs, ar_hs, wr_fire, wr_stb;
  logic [1:0] wr_sel;
  logic [7:0] wr_byte;
  logic       tx_push, tx_pop, tx_clr, rx_pop, rx_clr;
  logic       tx_empty, tx_full, tx_push_ok;
  logic       rx_empty, rx_full, rx_push_ok;
  logic [7:0] rx_head;
  logic       unused_ok;

  assign awready  = !rst && !aw_held_q && !bvalid_q;
  assign wready   = !rst && !w_held_q && !bvalid_q;
  assign arready  = !rst && !ar_pending_q && !rvalid_q;
  assign bvalid   = bvalid_q;
  assign bresp    = bresp_q;
  assign rvalid   = rvalid_q;
  assign rresp    = rresp_q;
  assign rdata    = rdata_q;
  assign tx_valid = !tx_empty;
  assign irq      = irq_q;
  assign unused_ok = ^{awaddr, araddr, wdata, wstrb};

  // Decode the write that executes this cycle; AW and W may come from the holding regs or the live bus.
  always_comb begin
    aw_hs   = awvalid && awready;
    w_hs    = wvalid && wready;
    ar_hs   = arvalid && arready;
    wr_sel  = aw_held_q ? awsel_q : awaddr[3:2];
    wr_byte = w_held_q ? wbyte_q : wdata[7:0];
    wr_stb  = w_held_q ? wstb_q : wstrb[0];
    wr_fire = (aw_held_q || aw_hs) && (w_held_q || w_hs);
    tx_push = wr_fire && (wr_sel == SEL_TX) && wr_stb;
    tx_clr  = wr_fire && (wr_sel == SEL_CTRL) && wr_stb && wr_byte[0];
    rx_clr  = wr_fire && (wr_sel == SEL_CTRL) && wr_stb && wr_byte[1];
    tx_pop  = tx_valid && tx_ready;
    rx_pop  = ar_pending_q && (arsel_q == SEL_RX) && !rx_empty;
  end

  uart_axil_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .clr(tx_clr), .push(tx_push), .din(wr_byte), .pop(tx_pop),
    .dout(tx_data), .empty(tx_empty), .full(tx_full), .push_ok(tx_push_ok)
  );

  uart_axil_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .clr(rx_clr), .push(rx_valid), .din(rx_data), .pop(rx_pop),
    .dout(rx_head), .empty(rx_empty), .full(rx_full), .push_ok(rx_push_ok)
  );

  // Next-state for both AXI channels, the control/status bits and the interrupt edge detector.
  always_comb begin
    aw_held_d       = aw_held_q;
    awsel_d         = awsel_q;
    w_held_d        = w_held_q;
    wbyte_d         = wbyte_q;
    wstb_d          = wstb_q;
    bvalid_d        = bvalid_q;
    bresp_d         = bresp_q;
    ar_pending_d    = ar_hs;
    arsel_d         = arsel_q;
    rvalid_d        = rvalid_q;
    rresp_d         = rresp_q;
    rdata_d         = rdata_q;
    ie_d            = ie_q;
    ovr_d           = ovr_q;
    rx_empty_prev_d = rx_empty;
    tx_empty_prev_d = tx_empty;

    if (aw_hs) awsel_d = awaddr[3:2];
    if (w_hs) begin
      wbyte_d = wdata[7:0];
      wstb_d  = wstrb[0];
    end

    if (wr_fire) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = (tx_push && !tx_push_ok) ? RESP_SLV : RESP_OKAY;
      if (wr_sel == SEL_CTRL && wr_stb) ie_d = wr_byte[4];
    end else begin
      if (aw_hs) aw_held_d = 1'b1;
      if (w_hs)  w_held_d  = 1'b1;
      if (bvalid_q && bready) bvalid_d = 1'b0;
    end

    if (ar_hs) arsel_d = araddr[3:2];

    if (ar_pending_q) begin
      rvalid_d = 1'b1;
      rresp_d  = RESP_OKAY;
      rdata_d  = '0;
      case (arsel_q)
        SEL_RX: begin
          if (rx_empty) rresp_d = RESP_SLV;
          else          rdata_d = DATAW'(rx_head);
        end
        SEL_STATUS: begin
          rdata_d = DATAW'({ovr_q, ie_q, tx_full, tx_empty, rx_full, !rx_empty});
          ovr_d   = 1'b0;
        end
        default: ;
      endcase
    end else if (rvalid_q && rready) begin
      rvalid_d = 1'b0;
    end

    // A fresh overrun outranks the clear-on-read so the event is not lost.
    if (rx_valid && !rx_push_ok && !rx_clr) ovr_d = 1'b1;

    irq_d = ie_q && ((rx_empty_prev_q && !rx_empty) || (!tx_empty_prev_q && tx_empty));
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_held_q       <= 1'b0;
      awsel_q         <= '0;
      w_held_q        <= 1'b0;
      wbyte_q         <= '0;
      wstb_q          <= 1'b0;
      bvalid_q        <= 1'b0;
      bresp_q         <= RESP_OKAY;
      ar_pending_q    <= 1'b0;
      arsel_q         <= '0;
      rvalid_q        <= 1'b0;
      rresp_q         <= RESP_OKAY;
      rdata_q         <= '0;
      ie_q            <= 1'b0;
      ovr_q           <= 1'b0;
      rx_empty_prev_q <= 1'b1;
      tx_empty_prev_q <= 1'b1;
      irq_q           <= 1'b0;
    end else begin
      aw_held_q       <= aw_held_d;
      awsel_q         <= awsel_d;
      w_held_q        <= w_held_d;
      wbyte_q         <= wbyte_d;
      wstb_q          <= wstb_d;
      bvalid_q        <= bvalid_d;
      bresp_q         <= bresp_d;
      ar_pending_q    <= ar_pending_d;
      arsel_q         <= arsel_d;
      rvalid_q        <= rvalid_d;
      rresp_q         <= rresp_d;
      rdata_q         <= rdata_d;
      ie_q            <= ie_d;
      ovr_q           <= ovr_d;
      rx_empty_prev_q <= rx_empty_prev_d;
      tx_empty_prev_q <= tx_empty_prev_d;
      irq_q           <= irq_d;
    end
  end
endmodule

// File: tb/tb_uart_axil_responder.sv
`timescale 1ns/1ps
// tb_uart_axil_responder: directed plus random traffic against a queue-based register model.
// Bus inputs change and outputs are sampled on the falling clock edge.
// All waits on the DUT are bounded; a global timeout ends the run.
module tb_uart_axil_responder;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [3:0]  awaddr, araddr, wstrb;
  logic [31:0] wdata, rdata;
  logic [1:0]  bresp, rresp;
  logic        tx_valid, tx_ready, rx_valid, irq;
  logic [7:0]  tx_data, rx_data;

  int checks = 0;
  int errors = 0;

  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  logic       ie_m, ovr_m;

  always #5 clk = ~clk;

  uart_axil_responder #(.ADDRW(4), .DATAW(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_data(rx_data), .irq(irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] status_m();
    return {26'b0, ovr_m, ie_m, txq.size() == DEPTH, txq.size() == 0,
            rxq.size() == DEPTH, rxq.size() != 0};
  endfunction

  task automatic model_reset();
    rxq.delete();
    txq.delete();
    ie_m  = 1'b0;
    ovr_m = 1'b0;
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic inj, input logic [7:0] rb, input string tag);
    logic [1:0] er;
    int n;
    er = 2'b00;
    if (inj) begin
      if (rxq.size() < DEPTH) rxq.push_back(rb);
      else ovr_m = 1'b1;
    end
    if (a[3:2] == 2'd1 && s[0]) begin
      if (txq.size() < DEPTH) txq.push_back(d[7:0]);
      else er = 2'b10;
    end
    if (a[3:2] == 2'd3 && s[0]) begin
      if (d[0]) txq.delete();
      if (d[1]) rxq.delete();
      ie_m = d[4];
    end
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    rx_valid = inj; rx_data = rb;
    n = 0;
    while (!(awready && wready) && n < 16) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".aw_w_ready"}, 32'(awready && wready), 32'd1);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; rx_valid = 1'b0;
    chk({tag, ".bvalid"}, 32'(bvalid), 32'd1);
    chk({tag, ".bresp"}, 32'(bresp), 32'(er));
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] a, input string tag);
    logic [31:0] ed;
    logic [1:0]  er;
    int n;
    ed = '0;
    er = 2'b00;
    if (a[3:2] == 2'd0) begin
      if (rxq.size() != 0) ed = 32'(rxq.pop_front());
      else er = 2'b10;
    end else if (a[3:2] == 2'd2) begin
      ed = status_m();
      ovr_m = 1'b0;
    end
    araddr = a; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 16) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".arready"}, 32'(arready), 32'd1);
    @(negedge clk);
    arvalid = 1'b0;
    chk({tag, ".rvalid_early"}, 32'(rvalid), 32'd0);
    @(negedge clk);
    chk({tag, ".rvalid"}, 32'(rvalid), 32'd1);
    chk({tag, ".rdata"}, rdata, ed);
    chk({tag, ".rresp"}, 32'(rresp), 32'(er));
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  task automatic rx_inject(input logic [7:0] b);
    if (rxq.size() < DEPTH) rxq.push_back(b);
    else ovr_m = 1'b1;
    rx_valid = 1'b1; rx_data = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic tx_take(input string tag);
    if (txq.size() == 0) begin
      chk({tag, ".tx_valid_idle"}, 32'(tx_valid), 32'd0);
    end else begin
      chk({tag, ".tx_valid"}, 32'(tx_valid), 32'd1);
      chk({tag, ".tx_data"}, 32'(tx_data), 32'(txq[0]));
      void'(txq.pop_front());
    end
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int n_irq;
    logic [7:0] rb;
    rst = 1'b1;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    awaddr = 0; araddr = 0; wdata = 0; wstrb = 0;
    tx_ready = 0; rx_valid = 0; rx_data = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst.awready", 32'(awready), 32'd0);
    chk("rst.wready", 32'(wready), 32'd0);
    chk("rst.arready", 32'(arready), 32'd0);
    chk("rst.outs", {26'b0, bvalid, rvalid, tx_valid, irq, bresp}, 32'd0);
    chk("rst.rdata", rdata, 32'd0);
    chk("rst.rresp", 32'(rresp), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle.ready", {29'b0, awready, wready, arready}, 32'd7);

    // Handshake byte to TX and out to the UART.
    axi_write(4'h4, 32'h99, 4'h1, 1'b0, 8'h0, "wr99");
    tx_take("tx99");
    chk("tx99.drained", 32'(tx_valid), 32'd0);

    // W three cycles ahead of AW, response held by bready low.
    txq.push_back(8'hAA);
    wdata = 32'hAA; wstrb = 4'h1; wvalid = 1'b1;
    chk("wfirst.wready", 32'(wready), 32'd1);
    @(negedge clk);
    wvalid = 1'b0;
    chk("wfirst.held", 32'(wready), 32'd0);
    chk("wfirst.nob", 32'(bvalid), 32'd0);
    repeat (2) @(negedge clk);
    awaddr = 4'h4; awvalid = 1'b1;
    chk("wfirst.awready", 32'(awready), 32'd1);
    @(negedge clk);
    awvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("wfirst.bvalid_hold", 32'(bvalid), 32'd1);
      chk("wfirst.ready_low", {30'b0, awready, wready}, 32'd0);
      @(negedge clk);
    end
    chk("wfirst.bresp", 32'(bresp), 32'd0);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk("wfirst.bdone", 32'(bvalid), 32'd0);
    tx_take("wfirst.tx");
    tx_take("wfirst.once");

    // TX write without byte strobe is harmless.
    axi_write(4'h4, 32'h55, 4'h0, 1'b0, 8'h0, "wr_nostrb");
    chk("wr_nostrb.tx", 32'(tx_valid), 32'd0);

    // RX overflow and sticky overrun.
    for (int i = 0; i < 16; i++) rx_inject(8'(8'h10 + i));
    rx_inject(8'h20);
    axi_read(4'h8, "stat_ovr");
    axi_read(4'h8, "stat_ovr_clr");
    for (int i = 0; i < 17; i++) axi_read(4'h0, "rx_drain");

    // Unmapped-direction accesses.
    axi_read(4'h4, "rd_tx");
    axi_read(4'hC, "rd_ctrl");
    axi_write(4'h0, 32'hFF, 4'hF, 1'b0, 8'h0, "wr_rx");
    axi_write(4'h8, 32'hFF, 4'hF, 1'b0, 8'h0, "wr_stat");
    axi_read(4'h8, "stat_after_ign");

    // TX full, SLVERR, ordered drain, then CTRL clear.
    for (int i = 0; i < 17; i++) axi_write(4'h4, $urandom, 4'h1, 1'b0, 8'h0, "tx_fill");
    axi_read(4'h8, "stat_txfull");
    for (int i = 0; i < 3; i++) tx_take("tx_order");
    axi_write(4'hC, 32'h13, 4'h0, 1'b0, 8'h0, "ctrl_nostrb");
    axi_read(4'h8, "stat_ctrl_nostrb");
    axi_write(4'hC, 32'h01, 4'h1, 1'b0, 8'h0, "ctrl_txclr");
    chk("ctrl_txclr.tx_valid", 32'(tx_valid), 32'd0);
    axi_read(4'h8, "stat_txclr");

    // Interrupt on RX going non-empty.
    axi_write(4'hC, 32'h10, 4'h1, 1'b0, 8'h0, "ctrl_ie");
    chk("irq.idle", 32'(irq), 32'd0);
    rb = 8'($urandom);
    rxq.push_back(rb);
    rx_valid = 1'b1; rx_data = rb;
    n_irq = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rx_valid = 1'b0;
      if (irq) n_irq++;
    end
    chk("irq.pulses", 32'(n_irq), 32'd1);

    // RX push in the same cycle as an RX clear.
    axi_write(4'hC, 32'h12, 4'h1, 1'b1, 8'($urandom), "ctrl_rxclr");
    axi_read(4'h8, "stat_rxclr");
    axi_read(4'h0, "rd_after_clr");

    // Random mix.
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 4))
        0: axi_write(4'h4, $urandom, 4'h1, 1'b0, 8'h0, "rnd_wr");
        1: rx_inject(8'($urandom));
        2: axi_read(4'h0, "rnd_rx");
        3: axi_read(4'h8, "rnd_stat");
        default: tx_take("rnd_tx");
      endcase
    end

    // Reset with AW held and a read pending.
    awaddr = 4'h4; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    chk("mid.aw_held", 32'(awready), 32'd0);
    araddr = 4'h8; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid.rst_rvalid", 32'(rvalid), 32'd0);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("mid.ready", {29'b0, awready, wready, arready}, 32'd7);
    chk("mid.rvalid", 32'(rvalid), 32'd0);
    wdata = 32'h77; wstrb = 4'h1; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    @(negedge clk);
    chk("mid.no_b", 32'(bvalid), 32'd0);
    awaddr = 4'h8; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    chk("mid.bvalid", 32'(bvalid), 32'd1);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk("mid.tx_empty", 32'(tx_valid), 32'd0);
    axi_read(4'h8, "mid.stat");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_axil_responder.md
# uart_axil_responder

AXI4-Lite slave that exposes a byte-wide UART core to the bus as a four-register peripheral: RX FIFO, TX FIFO, STATUS and CTRL. It sits at `UART_ADDR` on the interconnect. It answers the host-loader FSM's writes (e.g. `0x99`/`0xAA` handshake bytes) and reads (program byte count, payload). It buffers bytes in both directions between the bus and the serial core.

## Interface
- `ADDRW`, default 4: address bits decoded; only `addr[3:2]` selects a register, other bits are ignored.
- `DATAW`, default 32: AXI data width.
- `DEPTH`, default 16: entries per FIFO; must be a power of two and at least 2.
- Clocking and reset (already decided): one clock; reset is synchronous and active-high.
- `clk`  in  1  sole clock; everything samples on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `awvalid`/`awready`  in/out  1  write-address handshake.
- `awaddr`  in  `ADDRW`  write address.
- `wvalid`/`wready`  in/out  1  write-data handshake.
- `wdata`  in  `DATAW`  write data.
- `wstrb`  in  `DATAW/8`  byte strobes.
- `bvalid`/`bready`  out/in  1  write-response handshake.
- `bresp`  out  2  write response: `00` OKAY, `10` SLVERR.
- `arvalid`/`arready`  in/out  1  read-address handshake.
- `araddr`  in  `ADDRW`  read address.
- `rvalid`/`rready`  out/in  1  read-data handshake.
- `rdata`  out  `DATAW`  read data.
- `rresp`  out  2  read response, same encoding as `bresp`.
- `tx_valid`/`tx_ready`  out/in  1  byte stream to the UART transmitter.
- `tx_data`  out  8  byte to transmit.
- `rx_valid`  in  1  byte from the UART receiver.
- `rx_data`  in  8  received byte; there is no back-pressure on this side.
- `irq`  out  1  one-cycle interrupt pulse.

## Operation
- Register map, offsets in bytes:
  - `0x0` RX_FIFO: read only.
  - `0x4` TX_FIFO: write only.
  - `0x8` STATUS: read only.
  - `0xC` CTRL: write only.
- Write path: AW and W are captured independently into holding flags `aw_held` and `w_held`.
  - `awready = !aw_held && !bvalid`; `wready = !w_held && !bvalid`.
  - When both flags are set, the write executes in one cycle, both flags clear, and `bvalid` is set.
  - `bvalid` stays set until `bready`.
- Write effects:
  - TX_FIFO with `wstrb[0]=1`: push `wdata[7:0]`. If the TX FIFO is full, the byte is dropped and `bresp=10`.
  - TX_FIFO with `wstrb[0]=0`: no push, `bresp=00`.
  - CTRL, with `wstrb[0]` gating:
    - bit0 clears the TX FIFO.
    - bit1 clears the RX FIFO.
    - bit4 is stored as `ie`.
  - Writes to `0x0`/`0x8` are ignored and return `00`.
- Read path: `arready = !ar_pending && !rvalid`.
  - An AR handshake sets `ar_pending` and latches `araddr`.
  - The next cycle registers `rdata`/`rresp`, sets `rvalid` and clears `ar_pending`.
  - `rvalid` stays set until `rready`.
- Read effects:
  - RX_FIFO, non-empty: `rdata={0,head}`, pop at the same cycle `rdata` is registered, `rresp=00`.
  - RX_FIFO, empty: `rdata=0`, `rresp=10`, no pop.
  - STATUS: `rdata` bits are:
    - [0] rx non-empty
    - [1] rx full
    - [2] tx empty
    - [3] tx full
    - [4] `ie`
    - [5] overrun
    - all other bits 0
  - A STATUS read clears overrun, after its value has been captured.
  - `0x4`/`0xC`: `rdata=0`, `rresp=00`.
- UART side:
  - `tx_valid` = TX FIFO non-empty; `tx_data` = TX head (first-word fall-through).
  - A TX pop happens on `tx_valid && tx_ready`.
  - On `rx_valid`, push `rx_data`. If the RX FIFO is full and not being popped that cycle, drop the byte and set sticky overrun.
- `irq` pulses for one cycle when `ie=1` and either:
  - the RX FIFO goes empty to non-empty, or
  - the TX FIFO goes non-empty to empty.

## Timing
- Reset values:
  - `awready=wready=arready=0` during reset and 1 the cycle after, when idle.
  - `bvalid=rvalid=0`; `bresp=rresp=0`; `rdata=0`.
  - `tx_valid=0`; `irq=0`.
  - FIFOs empty; `ie=0`; overrun=0; `aw_held=w_held=ar_pending=0`.
  - Reset mid-transaction discards held and pending requests and any outstanding response.
- Latency:
  - AW/W same-cycle handshake: `bvalid` in the next cycle.
  - AR handshake: `rvalid` two cycles later (the capture cycle, then the registered response).
  - A FIFO push is visible to STATUS and to `tx_valid` one cycle after the push edge.
- FIFO counts are `$clog2(DEPTH)+1` bits; pointers wrap modulo `DEPTH`.
- Simultaneous push and pop:
  - Full FIFO: the push is accepted and the count is unchanged.
  - Empty FIFO: no pop occurs and the push succeeds.
- A CTRL clear in the same cycle as a push or pop on that FIFO: the clear wins and the concurrent push or pop is discarded.
- Read and write channels are independent; a read and a write may complete in the same cycle.

## Test plan
- Reset, then write `0x99` to `0x4` -> `bvalid` next cycle with `bresp=00`; then `tx_valid=1`, `tx_data=0x99`; `tx_ready` pulse -> `tx_valid=0`.
- W arrives 3 cycles before AW; `bready` held low 4 cycles -> exactly one push, `bvalid` held, `awready`/`wready` low while `bvalid` is set.
- Inject bytes 0x10..0x1F on `rx`, then 0x20 (17th, `DEPTH=16`) -> STATUS reads `0x03|0x04|0x20` (rx non-empty, rx full, tx empty, overrun); a second STATUS read shows the overrun bit cleared.
- Read `0x0` 16 times after the above -> 0x10..0x1F in order with `rresp=00`; 17th read -> `rdata=0`, `rresp=10`.
- Fill TX with 16 writes with `tx_ready=0`; 17th write -> `bresp=10`; write CTRL=`0x01` -> STATUS bit2=1, `tx_valid=0`.
- CTRL=`0x10`; inject one rx byte -> `irq` high exactly one cycle; `rx_valid` coincident with a CTRL=`0x12` write -> RX FIFO empty afterwards.
